// File: rtl/cache_store_pkg.sv
// Shared types for the cache data/tag store: miss-engine FSM states and word sizing.
package cache_store_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_RD,
    ST_WB,
    ST_FILL,
    ST_DONE
  } state_t;

endpackage

// File: rtl/cache_store_plru.sv
// Tree pseudo-LRU state per set: touch steers the tree away from the used way,
// the victim walk follows the tree bits from the root.
module cache_store_plru #(
  parameter int NUM_WAY  = 2,
  parameter int NUM_LINE = 256,
  parameter int INDEX_W  = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               touch_en,
  input  logic [INDEX_W-1:0] touch_index,
  input  logic [NUM_WAY-1:0] touch_way,
  input  logic [INDEX_W-1:0] rd_index,
  output logic [NUM_WAY-1:0] victim_way
);

  localparam int LEVELS    = $clog2(NUM_WAY);
  localparam int TREE_W    = (NUM_WAY > 1) ? NUM_WAY - 1 : 1;
  localparam int WAY_IDX_W = (NUM_WAY > 1) ? LEVELS : 1;

  logic [TREE_W-1:0]    r_tree [NUM_LINE];
  logic [TREE_W-1:0]    w_tree_nxt;
  logic [TREE_W-1:0]    w_rd_tree;
  logic [WAY_IDX_W-1:0] w_touch_idx;
  int                   w_tnode;
  int                   w_vnode;

  always_comb begin
    w_touch_idx = '0;
    for (int w = 0; w < NUM_WAY; w++)
      if (touch_way[w]) w_touch_idx = WAY_IDX_W'(w);
  end

  // Heap-ordered tree: node n has children 2n (bit 0) and 2n+1 (bit 1).
  always_comb begin
    w_tree_nxt = r_tree[touch_index];
    w_tnode    = 1;
    for (int l = LEVELS - 1; l >= 0; l--) begin
      w_tree_nxt[w_tnode-1] = ~w_touch_idx[l];
      w_tnode = 2 * w_tnode + int'(w_touch_idx[l]);
    end
  end

  always_comb begin
    w_rd_tree  = r_tree[rd_index];
    w_vnode    = 1;
    for (int l = 0; l < LEVELS; l++)
      w_vnode = 2 * w_vnode + int'(w_rd_tree[w_vnode-1]);
    victim_way = '0;
    victim_way[w_vnode-NUM_WAY] = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_LINE; i++) r_tree[i] <= '0;
    end else if (touch_en) begin
      r_tree[touch_index] <= w_tree_nxt;
    end
  end

endmodule

// File: rtl/cache_store.sv
// Cache tag/data store with lookup, store-hit write, invalidate, PLRU victim choice
// and a miss engine that writes back a dirty victim and refills the line beat by beat.
module cache_store
  import cache_store_pkg::*;
#(
  parameter  int NUM_WAY        = 2,
  parameter  int BYTES_PER_LINE = 16,
  parameter  int NUM_LINE       = 256,
  localparam int OFFSET_W       = $clog2(BYTES_PER_LINE),
  localparam int INDEX_W        = $clog2(NUM_LINE),
  localparam int TAG_W          = 32 - OFFSET_W - INDEX_W,
  localparam int WORDS          = BYTES_PER_LINE / 4,
  localparam int BANK_W         = $clog2(WORDS)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               lkp_valid,
  output logic               lkp_ready,
  input  logic [INDEX_W-1:0] lkp_index,
  input  logic [TAG_W-1:0]   lkp_tag,
  input  logic [BANK_W-1:0]  lkp_bank,
  output logic [NUM_WAY-1:0] hit_way,
  output logic               hit,
  output logic [31:0]        rdata,
  output logic [NUM_WAY-1:0] victim_way,
  output logic               victim_dirty,
  input  logic               st_valid,
  output logic               st_ready,
  input  logic [NUM_WAY-1:0] st_way,
  input  logic [INDEX_W-1:0] st_index,
  input  logic [BANK_W-1:0]  st_bank,
  input  logic [31:0]        st_data,
  input  logic [3:0]         st_strb,
  input  logic               miss_valid,
  output logic               miss_ready,
  input  logic [NUM_WAY-1:0] miss_way,
  input  logic [INDEX_W-1:0] miss_index,
  input  logic [TAG_W-1:0]   miss_tag,
  output logic               miss_done,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [31:0]        wb_data,
  output logic               wb_last,
  output logic [31:0]        wb_addr,
  input  logic               fill_valid,
  output logic               fill_ready,
  input  logic [31:0]        fill_data,
  input  logic               inv_valid,
  input  logic [NUM_WAY-1:0] inv_way,
  input  logic [INDEX_W-1:0] inv_index
);

  localparam int WAY_IDX_W = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1;

  function automatic logic [WAY_IDX_W-1:0] oh2idx(input logic [NUM_WAY-1:0] oh);
    oh2idx = '0;
    for (int w = 0; w < NUM_WAY; w++)
      if (oh[w]) oh2idx = WAY_IDX_W'(w);
  endfunction

  state_t               r_state, w_state_nxt;
  logic [BANK_W-1:0]    r_cnt, w_cnt_nxt;
  logic [NUM_LINE-1:0]  r_v [NUM_WAY];
  logic [NUM_LINE-1:0]  r_d [NUM_WAY];
  logic [TAG_W-1:0]     r_tag_mem  [NUM_WAY][NUM_LINE];
  logic [DATA_W-1:0]    r_bank_mem [NUM_WAY][WORDS][NUM_LINE];
  logic [TAG_W-1:0]     r_rd_tag   [NUM_WAY];
  logic [DATA_W-1:0]    r_rd_data  [NUM_WAY][WORDS];
  logic [INDEX_W-1:0]   r_lkp_index, r_miss_index;
  logic [NUM_WAY-1:0]   r_miss_way;
  logic [TAG_W-1:0]     r_miss_tag;

  logic                 w_idle, w_miss_acc, w_st_do, w_inv_do, w_lkp_acc;
  logic                 w_fill_hs, w_fill_commit, w_cnt_last, w_rd_en, w_victim_wb;
  logic [INDEX_W-1:0]   w_rd_index;
  logic [WAY_IDX_W-1:0] w_st_wi, w_miss_wi, w_miss_in_wi;
  logic [NUM_WAY-1:0]   w_free_way, w_plru_victim;
  logic                 w_found;

  assign w_idle        = (r_state == ST_IDLE);
  assign w_miss_acc    = w_idle & miss_valid;
  assign w_st_do       = w_idle & st_valid & ~miss_valid;
  assign w_inv_do      = w_idle & inv_valid & ~miss_valid & ~st_valid;
  assign w_lkp_acc     = lkp_valid & lkp_ready;
  assign w_cnt_last    = (r_cnt == BANK_W'(WORDS - 1));
  assign w_fill_hs     = (r_state == ST_FILL) & fill_valid;
  assign w_fill_commit = w_fill_hs & w_cnt_last;
  assign w_st_wi       = oh2idx(st_way);
  assign w_miss_wi     = oh2idx(r_miss_way);
  assign w_miss_in_wi  = oh2idx(miss_way);
  assign w_victim_wb   = r_v[w_miss_in_wi][miss_index] & r_d[w_miss_in_wi][miss_index];
  // The single read port serves lookups in IDLE and the victim line read in WB_RD.
  assign w_rd_en       = w_lkp_acc | (r_state == ST_WB_RD);
  assign w_rd_index    = (r_state == ST_WB_RD) ? r_miss_index : lkp_index;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    lkp_ready   = 1'b0;
    st_ready    = 1'b0;
    miss_ready  = 1'b0;
    wb_valid    = 1'b0;
    fill_ready  = 1'b0;
    miss_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        lkp_ready  = ~st_valid;
        st_ready   = 1'b1;
        miss_ready = 1'b1;
        if (miss_valid) w_state_nxt = w_victim_wb ? ST_WB_RD : ST_FILL;
      end
      ST_WB_RD: w_state_nxt = ST_WB;
      ST_WB: begin
        wb_valid = 1'b1;
        if (wb_ready) begin
          w_cnt_nxt = w_cnt_last ? '0 : r_cnt + 1'b1;
          if (w_cnt_last) w_state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        fill_ready = 1'b1;
        if (fill_valid) begin
          w_cnt_nxt = w_cnt_last ? '0 : r_cnt + 1'b1;
          if (w_cnt_last) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        miss_done   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      for (int w = 0; w < NUM_WAY; w++) begin
        r_v[w] <= '0;
        r_d[w] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      // The line being replaced is invalid until its last refill beat lands.
      if (w_miss_acc) begin
        r_v[w_miss_in_wi][miss_index] <= 1'b0;
        r_d[w_miss_in_wi][miss_index] <= 1'b0;
      end
      if (w_st_do) r_d[w_st_wi][st_index] <= 1'b1;
      if (w_inv_do)
        for (int w = 0; w < NUM_WAY; w++)
          if (inv_way[w]) begin
            r_v[w][inv_index] <= 1'b0;
            r_d[w][inv_index] <= 1'b0;
          end
      if (w_fill_commit) begin
        r_v[w_miss_wi][r_miss_index] <= 1'b1;
        r_d[w_miss_wi][r_miss_index] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_st_do)
      for (int k = 0; k < STRB_W; k++)
        if (st_strb[k]) r_bank_mem[w_st_wi][st_bank][st_index][8*k +: 8] <= st_data[8*k +: 8];
    if (w_fill_hs) r_bank_mem[w_miss_wi][r_cnt][r_miss_index] <= fill_data;
    if (w_fill_commit) r_tag_mem[w_miss_wi][r_miss_index] <= r_miss_tag;
    if (w_rd_en)
      for (int w = 0; w < NUM_WAY; w++) begin
        r_rd_tag[w] <= r_tag_mem[w][w_rd_index];
        for (int b = 0; b < WORDS; b++) r_rd_data[w][b] <= r_bank_mem[w][b][w_rd_index];
      end
    if (w_lkp_acc) r_lkp_index <= lkp_index;
    if (w_miss_acc) begin
      r_miss_way   <= miss_way;
      r_miss_index <= miss_index;
      r_miss_tag   <= miss_tag;
    end
  end

  // Lookup cycle 1: compare registered tags, pick the word, choose a victim.
  always_comb begin
    hit_way    = '0;
    rdata      = '0;
    w_free_way = '0;
    w_found    = 1'b0;
    for (int w = 0; w < NUM_WAY; w++) begin
      hit_way[w] = r_v[w][r_lkp_index] & (r_rd_tag[w] == lkp_tag);
      if (hit_way[w]) rdata = rdata | r_rd_data[w][lkp_bank];
      if (!w_found && !r_v[w][r_lkp_index]) begin
        w_free_way[w] = 1'b1;
        w_found       = 1'b1;
      end
    end
    victim_way   = w_found ? w_free_way : w_plru_victim;
    victim_dirty = 1'b0;
    for (int w = 0; w < NUM_WAY; w++)
      victim_dirty = victim_dirty | (victim_way[w] & r_v[w][r_lkp_index] & r_d[w][r_lkp_index]);
  end

  assign hit     = |hit_way;
  assign wb_data = r_rd_data[w_miss_wi][r_cnt];
  assign wb_last = (r_state == ST_WB) & w_cnt_last;
  assign wb_addr = {r_rd_tag[w_miss_wi], r_miss_index, {OFFSET_W{1'b0}}};

  cache_store_plru #(
    .NUM_WAY  (NUM_WAY),
    .NUM_LINE (NUM_LINE),
    .INDEX_W  (INDEX_W)
  ) u_plru (
    .clk         (clk),
    .resetn      (resetn),
    .touch_en    (w_st_do | w_fill_commit),
    .touch_index (w_fill_commit ? r_miss_index : st_index),
    .touch_way   (w_fill_commit ? r_miss_way : st_way),
    .rd_index    (r_lkp_index),
    .victim_way  (w_plru_victim)
  );

endmodule

// File: tb/tb_cache_store.sv
// Directed bench for cache_store: lookup, refill, store, write-back, PLRU, invalidate, reset abort.
module tb_cache_store;

  logic        clk, resetn;
  logic        lkp_valid, lkp_ready;
  logic [7:0]  lkp_index;
  logic [19:0] lkp_tag;
  logic [1:0]  lkp_bank;
  logic [1:0]  hit_way, victim_way;
  logic        hit, victim_dirty;
  logic [31:0] rdata;
  logic        st_valid, st_ready;
  logic [1:0]  st_way;
  logic [7:0]  st_index;
  logic [1:0]  st_bank;
  logic [31:0] st_data;
  logic [3:0]  st_strb;
  logic        miss_valid, miss_ready, miss_done;
  logic [1:0]  miss_way;
  logic [7:0]  miss_index;
  logic [19:0] miss_tag;
  logic        wb_valid, wb_ready, wb_last;
  logic [31:0] wb_data, wb_addr;
  logic        fill_valid, fill_ready;
  logic [31:0] fill_data;
  logic        inv_valid;
  logic [1:0]  inv_way;
  logic [7:0]  inv_index;

  int checks   = 0;
  int failures = 0;

  cache_store dut (
    .clk(clk), .resetn(resetn),
    .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_index(lkp_index),
    .lkp_tag(lkp_tag), .lkp_bank(lkp_bank), .hit_way(hit_way), .hit(hit),
    .rdata(rdata), .victim_way(victim_way), .victim_dirty(victim_dirty),
    .st_valid(st_valid), .st_ready(st_ready), .st_way(st_way), .st_index(st_index),
    .st_bank(st_bank), .st_data(st_data), .st_strb(st_strb),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_way(miss_way),
    .miss_index(miss_index), .miss_tag(miss_tag), .miss_done(miss_done),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_last(wb_last),
    .wb_addr(wb_addr), .fill_valid(fill_valid), .fill_ready(fill_ready),
    .fill_data(fill_data), .inv_valid(inv_valid), .inv_way(inv_way), .inv_index(inv_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue at one negedge, present tag/bank at the next and settle the cycle-1 outputs.
  task automatic lookup(input logic [7:0] idx, input logic [19:0] tag, input logic [1:0] bank);
    @(negedge clk);
    chk("lkp_ready", 32'(lkp_ready), 32'd1);
    lkp_valid = 1'b1;
    lkp_index = idx;
    @(negedge clk);
    lkp_valid = 1'b0;
    lkp_tag   = tag;
    lkp_bank  = bank;
    #1;
  endtask

  task automatic store(input logic [1:0] way, input logic [7:0] idx, input logic [1:0] bank,
                       input logic [31:0] data, input logic [3:0] strb);
    @(negedge clk);
    chk("st_ready", 32'(st_ready), 32'd1);
    st_valid = 1'b1; st_way = way; st_index = idx; st_bank = bank; st_data = data; st_strb = strb;
    @(negedge clk);
    st_valid = 1'b0;
  endtask

  task automatic miss(input logic [1:0] way, input logic [7:0] idx, input logic [19:0] tag);
    @(negedge clk);
    chk("miss_ready", 32'(miss_ready), 32'd1);
    miss_valid = 1'b1; miss_way = way; miss_index = idx; miss_tag = tag;
    @(negedge clk);
    miss_valid = 1'b0;
  endtask

  task automatic fill_line(input logic [31:0] base);
    for (int k = 0; k < 4; k++) begin
      int n;
      n = 0;
      @(negedge clk);
      while (!fill_ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("fill_ready", 32'(fill_ready), 32'd1);
      fill_valid = 1'b1;
      fill_data  = base + 32'(k);
    end
    @(negedge clk);
    fill_valid = 1'b0;
    chk("miss_done_pulse", 32'(miss_done), 32'd1);
    @(negedge clk);
    chk("miss_done_clear", 32'(miss_done), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_wb [4];
    int k, cyc;
    exp_wb = '{32'hA0, 32'h0000FFFF, 32'hA2, 32'hA3};
    resetn = 1'b0;
    lkp_valid = 0; lkp_index = 0; lkp_tag = 0; lkp_bank = 0;
    st_valid = 0; st_way = 0; st_index = 0; st_bank = 0; st_data = 0; st_strb = 0;
    miss_valid = 0; miss_way = 0; miss_index = 0; miss_tag = 0;
    wb_ready = 0; fill_valid = 0; fill_data = 0;
    inv_valid = 0; inv_way = 0; inv_index = 0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst_miss_ready", 32'(miss_ready), 32'd1);
    chk("rst_lkp_ready", 32'(lkp_ready), 32'd1);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_fill_ready", 32'(fill_ready), 32'd0);
    chk("rst_miss_done", 32'(miss_done), 32'd0);

    lookup(8'd5, 20'h123, 2'd0);
    chk("cold_hit", 32'(hit), 32'd0);
    chk("cold_victim", 32'(victim_way), 32'h1);
    chk("cold_vdirty", 32'(victim_dirty), 32'd0);

    miss(2'b01, 8'd5, 20'h123);
    fill_line(32'hA0);
    lookup(8'd5, 20'h123, 2'd2);
    chk("fill_hit_way", 32'(hit_way), 32'h1);
    chk("fill_rdata", rdata, 32'hA2);
    chk("fill_victim", 32'(victim_way), 32'h2);

    store(2'b01, 8'd5, 2'd1, 32'hFFFFFFFF, 4'b0011);
    lookup(8'd5, 20'h123, 2'd1);
    chk("st_rdata", rdata, 32'h0000FFFF);
    chk("st_hit_way", 32'(hit_way), 32'h1);

    miss(2'b10, 8'd5, 20'h456);
    fill_line(32'hB0);
    lookup(8'd5, 20'h123, 2'd1);
    chk("two_victim", 32'(victim_way), 32'h1);
    chk("two_vdirty", 32'(victim_dirty), 32'd1);
    lookup(8'd5, 20'h456, 2'd0);
    chk("way1_hit_way", 32'(hit_way), 32'h2);
    chk("way1_rdata", rdata, 32'hB0);

    store(2'b01, 8'd5, 2'd0, 32'h0, 4'b0000);
    lookup(8'd5, 20'h123, 2'd0);
    chk("touch0_victim", 32'(victim_way), 32'h2);
    chk("touch0_vdirty", 32'(victim_dirty), 32'd0);
    chk("touch0_rdata", rdata, 32'hA0);
    store(2'b10, 8'd5, 2'd0, 32'h0, 4'b0000);
    lookup(8'd5, 20'h123, 2'd0);
    chk("touch1_victim", 32'(victim_way), 32'h1);
    chk("touch1_vdirty", 32'(victim_dirty), 32'd1);

    miss(2'b01, 8'd5, 20'h789);
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 40) begin
      @(negedge clk);
      wb_ready = cyc[0];
      #1;
      if (wb_valid) begin
        chk("wb_addr", wb_addr, 32'h00123050);
        chk("wb_data", wb_data, exp_wb[k]);
        if (wb_ready) begin
          chk("wb_last", 32'(wb_last), (k == 3) ? 32'd1 : 32'd0);
          k++;
        end
      end
      cyc++;
    end
    chk("wb_beats", 32'(k), 32'd4);
    @(negedge clk);
    wb_ready = 1'b0;
    chk("wb_done_valid", 32'(wb_valid), 32'd0);
    fill_line(32'hC0);
    lookup(8'd5, 20'h789, 2'd3);
    chk("refill_hit_way", 32'(hit_way), 32'h1);
    chk("refill_rdata", rdata, 32'hC3);

    @(negedge clk);
    inv_valid = 1'b1; inv_way = 2'b01; inv_index = 8'd5;
    @(negedge clk);
    inv_valid = 1'b0;
    lookup(8'd5, 20'h789, 2'd3);
    chk("inv_hit", 32'(hit), 32'd0);
    chk("inv_rdata", rdata, 32'd0);
    chk("inv_victim", 32'(victim_way), 32'h1);

    miss(2'b01, 8'd5, 20'h123);
    @(negedge clk);
    chk("abort_fill_ready", 32'(fill_ready), 32'd1);
    fill_valid = 1'b1; fill_data = 32'hD0;
    @(negedge clk);
    fill_data = 32'hD1;
    @(negedge clk);
    fill_valid = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("abort_miss_ready", 32'(miss_ready), 32'd1);
    chk("abort_fill_idle", 32'(fill_ready), 32'd0);
    chk("abort_done", 32'(miss_done), 32'd0);
    lookup(8'd5, 20'h123, 2'd0);
    chk("abort_hit", 32'(hit), 32'd0);
    lookup(8'd5, 20'h456, 2'd0);
    chk("abort_way1_hit", 32'(hit), 32'd0);
    chk("abort_victim", 32'(victim_way), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
